// File: rtl/mem_stage_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_sram_ctrl
// Purpose : MEM-stage data-access controller. It splits each 32-bit load or
//           store into two 16-bit SRAM accesses, low half first. While an
//           access is in flight it holds ready low to freeze the pipeline.
//           For loads it assembles the 32-bit result for the MEM/WB register.
// Revision: 1.0 - initial release
// ============================================================================
module mem_stage_sram_ctrl #(
  parameter int BASE_ADDR   = 1024,  // byte address mapped to SRAM word 0
  parameter int WAIT_CYCLES = 2      // cycles per 16-bit half, >= 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_i,
  output logic        sram_we_n
);

  localparam int CNT_W = $clog2(WAIT_CYCLES);
  // Counter value on the final cycle of a half access
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(WAIT_CYCLES - 1);
  // Counter value one cycle before the final cycle; WE is raised from here on
  localparam logic [CNT_W-1:0] PRELAST_CNT = CNT_W'(WAIT_CYCLES - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [16:0]      r_idx;
  logic [15:0]      r_wdata_hi;
  logic             r_is_wr;

  logic             w_req;
  logic [16:0]      w_idx;

  assign w_req = mem_r_en | mem_w_en;
  // Word index inside the SRAM; addresses outside the window simply wrap
  assign w_idx = 17'((addr - 32'(BASE_ADDR)) >> 2);

  // Pipeline is released when idle with nothing to do, or on the hand-off cycle
  assign ready = ((r_state == S_IDLE) & ~w_req) | (r_state == S_DONE);

  // Access sequencer: SRAM bus outputs are registered and set up one cycle ahead
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_wdata_hi <= '0;
      r_is_wr    <= 1'b0;
      rdata      <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_we_n  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            // A store wins when both enables are raised together
            r_idx      <= w_idx;
            r_wdata_hi <= wdata[31:16];
            r_is_wr    <= mem_w_en;
            r_cnt      <= '0;
            r_state    <= S_LO;
            sram_addr  <= {w_idx, 1'b0};
            sram_dq_o  <= wdata[15:0];
            sram_dq_oe <= mem_w_en;
            sram_we_n  <= ~mem_w_en;
          end
        end
        S_LO: begin
          if (r_cnt == LAST_CNT) begin
            if (!r_is_wr) begin
              rdata[15:0] <= sram_dq_i;
            end
            r_cnt     <= '0;
            r_state   <= S_HI;
            sram_addr <= {r_idx, 1'b1};
            sram_dq_o <= r_wdata_hi;
            sram_we_n <= ~r_is_wr;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            // Deassert WE for the last cycle so the address holds across its rising edge
            if (r_cnt == PRELAST_CNT) begin
              sram_we_n <= 1'b1;
            end
          end
        end
        S_HI: begin
          if (r_cnt == LAST_CNT) begin
            if (!r_is_wr) begin
              rdata[31:16] <= sram_dq_i;
            end
            r_cnt      <= '0;
            r_state    <= S_DONE;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == PRELAST_CNT) begin
              sram_we_n <= 1'b1;
            end
          end
        end
        S_DONE: begin
          // Pipeline advances on this edge, so the held request is not restarted
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_stage_sram_ctrl
// Purpose : Scoreboard bench for mem_stage_sram_ctrl. The stimulus pushes the
//           expected outcome of every request. A negedge monitor pops and
//           checks each result when the DUT releases ready.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_stage_sram_ctrl;

  localparam int BASE = 1024;
  localparam int W    = 2;
  localparam int LAT  = 2 * W + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_i;
  logic        sram_we_n;

  always #5 clk = ~clk;

  mem_stage_sram_ctrl #(.BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_we_n(sram_we_n)
  );

  // External SRAM: asynchronous read, write committed at the end of a WE-low cycle
  logic [15:0] sram_mem [0:262143];
  assign sram_dq_i = sram_mem[sram_addr];
  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_o;
  end

  typedef struct {
    logic        is_wr;
    logic [16:0] idx;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_word [int];   // reference memory: 32-bit words by word index
  logic [31:0] model_rdata = '0;   // what the load-data register should hold
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: accumulates bus observations per request, checks on ready
  int   mon_cyc = 0;
  int   mon_we_lo = 0;
  int   mon_oe = 0;
  logic mon_bus_ok = 1'b1;
  exp_t cur;
  always @(negedge clk) begin
    if (rst) begin
      mon_cyc = 0; mon_we_lo = 0; mon_oe = 0; mon_bus_ok = 1'b1;
    end else if ((mem_r_en || mem_w_en) && sb.size() > 0) begin
      cur = sb[0];
      if (!sram_we_n) begin
        mon_we_lo++;
        if (sram_addr[17:1] !== cur.idx ||
            sram_dq_o !== (sram_addr[0] ? cur.wdata[31:16] : cur.wdata[15:0]))
          mon_bus_ok = 1'b0;
      end
      if (sram_dq_oe) mon_oe++;
      if (ready) begin
        void'(sb.pop_front());
        chk("rdata", rdata, cur.exp_rdata);
        chk("latency", 32'(mon_cyc), 32'(LAT));
        chk("we_n_low_cycles", 32'(mon_we_lo), cur.is_wr ? 32'(2 * (W - 1)) : 32'd0);
        chk("dq_oe_cycles", 32'(mon_oe), cur.is_wr ? 32'(2 * W) : 32'd0);
        chk("bus_addr_data", {31'd0, mon_bus_ok}, 32'd1);
        mon_cyc = 0; mon_we_lo = 0; mon_oe = 0; mon_bus_ok = 1'b1;
      end else begin
        mon_cyc++;
      end
    end
  end

  // Per-cycle trace of the most recent request, cycle 0 = first request cycle
  logic        tr_rdy  [0:63];
  logic        tr_we   [0:63];
  logic [17:0] tr_addr [0:63];
  logic [31:0] tr_rd   [0:63];

  task automatic run_req(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [16:0] idx);
    exp_t e;
    int   k;
    bit   done;
    e.is_wr = w;
    e.idx   = idx;
    e.wdata = d;
    if (w) begin
      model_word[int'(idx)] = d;
      e.exp_rdata = model_rdata;
    end else begin
      e.exp_rdata = model_word.exists(int'(idx)) ? model_word[int'(idx)] : 32'h0;
      model_rdata = e.exp_rdata;
    end
    sb.push_back(e);
    mem_r_en = r; mem_w_en = w; addr = a; wdata = d;
    k = 0; done = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      tr_rdy[k] = ready; tr_we[k] = sram_we_n; tr_addr[k] = sram_addr; tr_rd[k] = rdata;
      if (ready) done = 1; else k++;
    end
    if (!done) chk("handshake_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    mem_r_en = 1'b0; mem_w_en = 1'b0; addr = $urandom; wdata = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Random-phase slots: 16 words from the base plus two that wrap below it
  function automatic logic [16:0] idx_for(input int s);
    if (s < 16) return 17'(s);
    return (s == 16) ? 17'h1FFFF : 17'h1FFFE;
  endfunction

  function automatic logic [31:0] addr_for(input int s, input int lo);
    if (s < 16) return 32'(BASE + s * 4 + lo);
    return (s == 16) ? 32'(BASE - 4 + lo) : 32'(BASE - 8 + lo);
  endfunction

  logic [5:0] vec;

  initial begin
    // Reset state, with an idle bus
    @(negedge clk);
    chk("rst_ctl", {29'd0, ready, sram_we_n, sram_dq_oe}, 32'b110);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_sram_addr", {14'd0, sram_addr}, 32'h0);
    chk("rst_dq_o", {16'd0, sram_dq_o}, 32'h0);
    mem_r_en = 1'b1; #1;
    chk("rst_ready_follows_req", {31'd0, ready}, 32'd0);
    mem_r_en = 1'b0;
    @(posedge clk); #1; rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ctl", {29'd0, ready, sram_we_n, sram_dq_oe}, 32'b110);
    end
    @(posedge clk); #1;

    // Store 0xDEADBEEF at word 0, then load it back with a cycle trace
    run_req(1'b0, 1'b1, 32'h400, 32'hDEADBEEF, 17'd0);
    run_req(1'b1, 1'b0, 32'h400, 32'h0BADF00D, 17'd0);
    for (int i = 0; i < 6; i++) vec[i] = tr_rdy[i];
    chk("rd_ready_seq", {26'd0, vec}, 32'b100000);
    for (int c = 1; c <= 4; c++)
      chk($sformatf("rd_sram_addr_c%0d", c), {14'd0, tr_addr[c]}, (c < 3) ? 32'd0 : 32'd1);
    chk("rd_rdata_between_halves", tr_rd[3], 32'h0000BEEF);
    chk("rd_rdata_final", tr_rd[5], 32'hDEADBEEF);

    // Store with WE timing trace
    run_req(1'b0, 1'b1, 32'h408, 32'h12345678, 17'd2);
    for (int i = 0; i < 6; i++) vec[i] = tr_we[i];
    chk("wr_we_n_seq", {26'd0, vec}, 32'b110101);
    chk("wr_sram_lo", {16'd0, sram_mem[4]}, 32'h5678);
    chk("wr_sram_hi", {16'd0, sram_mem[5]}, 32'h1234);
    idle(2);

    // Back-to-back store then load of the same word
    run_req(1'b0, 1'b1, 32'h40C, 32'hCAFEF00D, 17'd3);
    run_req(1'b1, 1'b0, 32'h40C, 32'h0, 17'd3);
    chk("b2b_load_starts_busy", {31'd0, tr_rdy[0]}, 32'd0);

    // Both enables: behaves as a store
    run_req(1'b1, 1'b1, 32'h410, 32'hA5A55A5A, 17'd4);
    chk("both_en_sram_lo", {16'd0, sram_mem[8]}, 32'h5A5A);
    chk("both_en_sram_hi", {16'd0, sram_mem[9]}, 32'hA5A5);

    // Reset in cycle 2 of a store, request released at the same time
    mem_w_en = 1'b1; addr = 32'h590; wdata = 32'h11112222;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; mem_w_en = 1'b0;
    @(negedge clk);
    chk("midrst_ctl", {29'd0, ready, sram_we_n, sram_dq_oe}, 32'b110);
    chk("midrst_sram_addr", {14'd0, sram_addr}, 32'h0);
    chk("midrst_rdata", rdata, 32'h0);
    model_rdata = 32'h0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle_ready", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    run_req(1'b1, 1'b0, 32'h40C, 32'h0, 17'd3);

    // Initialise every random slot, then mixed random traffic
    for (int s = 0; s < 18; s++)
      run_req(1'b0, 1'b1, addr_for(s, $urandom_range(0, 3)), $urandom, idx_for(s));
    for (int n = 0; n < 150; n++) begin
      int s, op;
      s  = $urandom_range(0, 17);
      op = $urandom_range(0, 3);
      run_req((op != 2), (op >= 2), addr_for(s, $urandom_range(0, 3)), $urandom, idx_for(s));
      idle($urandom_range(0, 2));
    end

    idle(3);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
